// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, memory base address.
package lsu_pkg;

  localparam logic [31:0] LSU_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t IDLE   = 3'd0;
  localparam lsu_state_t LOAD   = 3'd1;
  localparam lsu_state_t RMW_RD = 3'd2;
  localparam lsu_state_t WRITE  = 3'd3;
  localparam lsu_state_t RESP   = 3'd4;
  localparam lsu_state_t RESP_F = 3'd5;

endpackage

// File: rtl/lsu_lane_logic.sv
// Combinational lane handling: merges sub-word store data into a memory word and
// extracts/extends the addressed byte or half of a loaded word.
module lsu_lane_logic
  import lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = load_word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = load_word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]     = store_data_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      default: merged_o = store_data_i;
    endcase
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: word-wide memory accesses with read-modify-write for
// sub-word stores, load extension and misalign/range/size fault detection.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = LSU_BASE_ADDR,
  parameter int unsigned           MEMORY_DEPTH = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_fault_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(MEMORY_DEPTH) << 2;

  lsu_state_t            state_q, state_d;
  logic                  write_q, write_d;
  lsu_size_e             size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  // Holds the loaded word, the merged RMW word, or the SW data depending on the op.
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic [DATA_WIDTH-1:0] req_offset;
  logic                  req_fault;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] load_data;

  // Addresses below BASE_ADDR wrap to a large offset and fall outside SPAN.
  assign req_offset = req_addr_i - BASE_ADDR;

  always_comb begin
    req_fault = (req_offset >= SPAN);
    case (req_size_i)
      SZ_HALF:    req_fault = req_fault | req_addr_i[0];
      SZ_WORD:    req_fault = req_fault | (req_addr_i[1:0] != 2'b00);
      SZ_ILLEGAL: req_fault = 1'b1;
      default:    ;
    endcase
  end

  lsu_lane_logic u_lane_logic (
    .size_i       (size_q),
    .lane_i       (addr_q[1:0]),
    .unsigned_i   (unsigned_q),
    .store_data_i (wdata_q),
    .old_word_i   (mem_rdata_i),
    .load_word_i  (word_q),
    .merged_o     (merged_word),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d    = req_write_i;
          size_d     = lsu_size_e'(req_size_i);
          unsigned_d = req_unsigned_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          if (req_fault) begin
            state_d = RESP_F;
          end else if (!req_write_i) begin
            state_d = LOAD;
          end else if (req_size_i == SZ_WORD) begin
            word_d  = req_wdata_i;
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        word_d  = mem_rdata_i;
        state_d = RESP;
      end
      RMW_RD: begin
        word_d  = merged_word;
        state_d = WRITE;
      end
      WRITE:        state_d = RESP;
      RESP, RESP_F: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    stall_o      = (state_q != IDLE);
    mem_read_o   = (state_q == LOAD) || (state_q == RMW_RD);
    mem_write_o  = (state_q == WRITE);
    mem_addr_o   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    mem_wdata_o  = word_q;
    resp_valid_o = (state_q == RESP) || (state_q == RESP_F);
    resp_fault_o = (state_q == RESP_F);
    resp_rdata_o = ((state_q == RESP) && !write_q) ? load_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic against a
// word-array reference model.
module tb_load_store_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 8192;
  localparam logic [31:0] SPAN  = 32'd4 * 32'd8192;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall_o, resp_valid, resp_fault, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [31:0] last_rdata;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] ref_mem [int];
  logic [31:0] mem_off;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid),
    .req_write_i    (req_write),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .stall_o        (stall_o),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_fault_o   (resp_fault),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  // Data memory with combinational read and clocked write.
  assign mem_off   = mem_addr - BASE;
  assign mem_rdata = (mem_off < SPAN) ? mem_model[mem_off[14:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write && mem_off < SPAN) mem_model[mem_off[14:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit exp_fault(input logic [1:0] sz, input logic [31:0] a);
    longint la;
    bit     in_range;
    la       = a;
    in_range = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    return (sz == 2'd3) || (sz == 2'd1 && la % 2 != 0) || (sz == 2'd2 && la % 4 != 0) || !in_range;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a);
    longint w, v;
    int     sh;
    w  = ref_mem[word_idx(a)];
    sh = int'(a % 4) * 8;
    case (sz)
      2'd0: begin
        v = (w >> sh) % 256;
        if (!uns && v >= 128) v -= 256;
      end
      2'd1: begin
        sh = (sh >= 16) ? 16 : 0;
        v  = (w >> sh) % 65536;
        if (!uns && v >= 32768) v -= 65536;
      end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    longint w, m, dd;
    int     sh;
    w  = ref_mem.exists(word_idx(a)) ? ref_mem[word_idx(a)] : 32'h0;
    dd = d;
    sh = int'(a % 4) * 8;
    case (sz)
      2'd0: begin
        m = longint'(255) << sh;
        w = (w & ~m) | ((dd % 256) << sh);
      end
      2'd1: begin
        sh = (sh >= 16) ? 16 : 0;
        m  = longint'(65535) << sh;
        w  = (w & ~m) | ((dd % 65536) << sh);
      end
      default: w = dd;
    endcase
    ref_mem[word_idx(a)] = w[31:0];
  endtask

  // ---------------- transaction driver ----------------
  task automatic wait_idle();
    int guard = 0;
    while (stall_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (stall_o) check_eq("idle_timeout", 32'(stall_o), 32'd0);
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
    int          lat, stalls, rds, wrs, exp_lat, exp_rds, exp_wrs;
    bit          f, done;
    logic [31:0] exp_rd, got_rd;
    logic        got_f;
    wait_idle();
    f       = exp_fault(sz, a);
    exp_rd  = (!f && !w) ? exp_load(sz, uns, a) : 32'h0;
    exp_lat = f ? 1 : (!w || sz == 2'd2) ? 2 : 3;
    exp_rds = (f || (w && sz == 2'd2)) ? 0 : 1;
    exp_wrs = (!f && w) ? 1 : 0;
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; stalls = 0; rds = 0; wrs = 0; done = 0; got_rd = 32'h0; got_f = 1'b0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (stall_o) stalls++;
      if (mem_read) rds++;
      if (mem_write) wrs++;
      if (resp_valid) begin
        done   = 1;
        got_rd = resp_rdata;
        got_f  = resp_fault;
      end
    end
    check_eq("resp_seen", 32'(done), 32'd1);
    check_eq("fault", 32'(got_f), 32'(f));
    check_eq("rdata", got_rd, exp_rd);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("stall_cycles", 32'(stalls), 32'(exp_lat));
    check_eq("mem_reads", 32'(rds), 32'(exp_rds));
    check_eq("mem_writes", 32'(wrs), 32'(exp_wrs));
    if (!f && w) begin
      model_store(sz, a, d);
      check_eq("mem_word", mem_model[word_idx(a)], ref_mem[word_idx(a)]);
    end
    last_rdata = got_rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          nresp;
    logic        w, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    #12;
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_fault", 32'(resp_fault), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset while an SB sits in WRITE must leave the word untouched.
    do_req(1'b1, 2'd2, 1'b0, BASE, 32'h1122_3344);
    wait_idle();
    req_write = 1'b1; req_size = 2'd0; req_addr = BASE; req_wdata = 32'h0000_00AA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_rmw_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    check_eq("abort_write_phase", 32'(mem_write), 32'd1);
    check_eq("abort_merged", mem_wdata, 32'h1122_33AA);
    check_eq("abort_addr", mem_addr, BASE);
    reset = 1'b0;
    #1;
    check_eq("abort_write_drop", 32'(mem_write), 32'd0);
    check_eq("abort_stall_drop", 32'(stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_eq("abort_mem_kept", mem_model[0], 32'h1122_3344);
    @(negedge clk);
    do_req(1'b0, 2'd2, 1'b0, BASE, 32'h0);
    check_eq("abort_lw", last_rdata, 32'h1122_3344);

    do_req(1'b1, 2'd2, 1'b0, BASE + 32'h4, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    check_eq("lw_deadbeef", last_rdata, 32'hDEAD_BEEF);

    do_req(1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'h80F1_7F01);
    do_req(1'b0, 2'd0, 1'b0, BASE + 32'hA, 32'h0);
    check_eq("lb_0a", last_rdata, 32'hFFFF_FFF1);
    do_req(1'b0, 2'd0, 1'b1, BASE + 32'hA, 32'h0);
    check_eq("lbu_0a", last_rdata, 32'h0000_00F1);
    do_req(1'b0, 2'd1, 1'b0, BASE + 32'hA, 32'h0);
    check_eq("lh_0a", last_rdata, 32'hFFFF_80F1);

    do_req(1'b1, 2'd2, 1'b0, BASE + 32'hC, 32'hAABB_CCDD);
    do_req(1'b1, 2'd0, 1'b0, BASE + 32'hD, 32'h0000_0055);
    do_req(1'b0, 2'd2, 1'b0, BASE + 32'hC, 32'h0);
    check_eq("sb_merge", last_rdata, 32'hAABB_55DD);
    do_req(1'b1, 2'd1, 1'b0, BASE + 32'hE, 32'h0000_1234);
    do_req(1'b0, 2'd2, 1'b0, BASE + 32'hC, 32'h0);
    check_eq("sh_merge", last_rdata, 32'h1234_55DD);

    // Faults: misaligned, below base, past end, illegal size.
    do_req(1'b0, 2'd2, 1'b0, BASE + 32'h2, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, BASE + 32'h1, 32'h0000_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, BASE + SPAN, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, BASE, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, BASE + 32'h4, 32'h1);

    // Back-to-back SW then LW with req_valid held high.
    wait_idle();
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = BASE + 32'h10; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_write = 1'b0; req_wdata = 32'h0;
    nresp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        nresp++;
        if (nresp == 2) check_eq("b2b_lw_rdata", resp_rdata, 32'hCAFE_F00D);
        if (nresp == 1) begin
          check_eq("b2b_sw_fault", 32'(resp_fault), 32'd0);
          @(posedge clk);
          @(posedge clk);
          #1 req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check_eq("b2b_resp_count", 32'(nresp), 32'd2);
    model_store(2'd2, BASE + 32'h10, 32'hCAFE_F00D);

    // Randomized traffic over a preloaded window plus the last word.
    for (int i = 0; i < 64; i++) do_req(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), $urandom);
    do_req(1'b1, 2'd2, 1'b0, BASE + SPAN - 32'd4, $urandom);
    for (int i = 0; i < 300; i++) begin
      w   = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 15));
      sz  = (r == 0) ? 2'd3 : 2'(r % 3);
      r   = int'($urandom_range(0, 19));
      if (r < 16)       a = BASE + $urandom_range(0, 255);
      else if (r == 16) a = BASE + SPAN - 32'd4 + $urandom_range(0, 3);
      else if (r == 17) a = BASE + SPAN + $urandom_range(0, 7);
      else if (r == 18) a = BASE - $urandom_range(1, 8);
      else              a = $urandom | 32'h8000_0000;
      do_req(w, sz, uns, a, $urandom);
    end

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
